// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx core between REQ_NUM byte-stream requesters. Round-robin arbitration with
//   packet lock: the granted requester keeps the transmitter until its last byte, or until it has
//   stalled mid-packet for LOCK_TIMEOUT cycles. Each byte is paced against send_en/send_busy.
//
// Ports
//   clk, rst_n   system clock; asynchronous active-low reset
//   req_valid    per-requester byte available
//   req_data     byte lanes, lane i = [i*8 +: 8]
//   req_last     byte on lane i ends its packet
//   req_ready    one-cycle accept strobe, only ever on the owner's lane
//   grant_oh     one-hot current owner, 0 when idle
//   send_en      one-cycle start strobe to uart_tx
//   send_data    byte to uart_tx, held after send_en
//   send_busy    uart_tx frame in progress
//   lock_abort   one-cycle pulse when a stalled lock is forcibly released

module uart_tx_arbiter #(
    parameter int unsigned REQ_NUM      = 2,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned BUSY_WAIT    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REQ_NUM-1:0]   req_valid,
    input  logic [REQ_NUM*8-1:0] req_data,
    input  logic [REQ_NUM-1:0]   req_last,
    output logic [REQ_NUM-1:0]   req_ready,
    output logic [REQ_NUM-1:0]   grant_oh,
    output logic                 send_en,
    output logic [7:0]           send_data,
    input  logic                 send_busy,
    output logic                 lock_abort
);

    localparam int unsigned PtrW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int unsigned TmrW = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned BwW  = $clog2(BUSY_WAIT + 1);

    typedef enum logic [1:0] {StIdle, StSend, StWaitBusy, StWaitDone} state_e;

    state_e state_q, state_d;

    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [PtrW-1:0]    owner_q, owner_d;
    logic [REQ_NUM-1:0] grant_q, grant_d;
    logic [TmrW-1:0]    timer_q, timer_d;
    logic [BwW-1:0]     bw_q, bw_d;
    logic               send_en_q, send_en_d;
    logic [7:0]         data_q, data_d;
    logic               last_q, last_d;
    logic               abort_q, abort_d;

    logic               any_valid;
    logic [PtrW-1:0]    winner;
    logic [PtrW-1:0]    ptr_after_owner;
    logic               owner_valid;
    logic               owner_last;
    logic [7:0]         owner_data;
    logic               accept;
    int unsigned        idx;

    assign owner_valid = req_valid[owner_q];
    assign owner_last  = req_last[owner_q];
    assign owner_data  = req_data[{owner_q, 3'b000} +: 8];
    assign accept      = (state_q == StSend) && owner_valid && !send_busy;

    // Released owner drops to lowest priority.
    assign ptr_after_owner = (owner_q == PtrW'(REQ_NUM - 1)) ? '0 : owner_q + 1'b1;

    // First valid requester scanning upward from ptr_q, wrapping at REQ_NUM.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= REQ_NUM) begin
                idx = idx - REQ_NUM;
            end
            if (!any_valid && req_valid[PtrW'(idx)]) begin
                any_valid = 1'b1;
                winner    = PtrW'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            timer_q   <= '0;
            bw_q      <= '0;
            send_en_q <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            timer_q   <= timer_d;
            bw_q      <= bw_d;
            send_en_q <= send_en_d;
            data_q    <= data_d;
            last_q    <= last_d;
            abort_q   <= abort_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        timer_d   = timer_q;
        bw_d      = bw_q;
        send_en_d = 1'b0;
        data_d    = data_q;
        last_d    = last_q;
        abort_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    owner_d = winner;
                    for (int unsigned i = 0; i < REQ_NUM; i++) begin
                        grant_d[i] = (winner == PtrW'(i));
                    end
                    timer_d = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (accept) begin
                    send_en_d = 1'b1;
                    data_d    = owner_data;
                    last_d    = owner_last;
                    timer_d   = '0;
                    bw_d      = '0;
                    state_d   = StWaitBusy;
                end else if (timer_q == TmrW'(LOCK_TIMEOUT - 1)) begin
                    // Owner stalled mid-packet: release the lock so others are not starved.
                    abort_d = 1'b1;
                    ptr_d   = ptr_after_owner;
                    grant_d = '0;
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWaitBusy: begin
                // Bounded so a missed busy edge cannot hang the arbiter.
                if (send_busy || (bw_q == BwW'(BUSY_WAIT - 1))) begin
                    state_d = StWaitDone;
                end else begin
                    bw_d = bw_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!send_busy) begin
                    if (last_q) begin
                        ptr_d   = ptr_after_owner;
                        grant_d = '0;
                        state_d = StIdle;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
        endcase
    end

    // Outputs.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[owner_q] = 1'b1;
        end
        grant_oh   = grant_q;
        send_en    = send_en_q;
        send_data  = data_q;
        lock_abort = abort_q;
    end

endmodule
